// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the asynchronous FIFO write side.
// NREQ valid/ready requesters share one winc/wdata port. A grant lasts for a
// burst of up to MAXBURST beats. Writes stall on the registered wfull flag.
// When AWFULL_GATE is "TRUE", no new grant is issued while awfull is high.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int    NREQ        = 4,
  parameter int    DSIZE       = 8,
  parameter int    MAXBURST    = 4,
  parameter string AWFULL_GATE = "TRUE"
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  input  logic                    awfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [NREQ-1:0]         grant,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXBURST + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [BW-1:0] BCNT_END = BW'(MAXBURST - 1);
  localparam bit GATE_EN = (AWFULL_GATE == "TRUE");

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  int                cand;
  logic              in_burst;
  logic              own_valid;
  logic              own_last;
  logic              xfer;
  logic [PW-1:0]     ptr_inc;

  // Round-robin search: lowest offset from ptr with a valid request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  // Write-port datapath: only the owner sees ready, and only while not full.
  always_comb begin
    in_burst  = (state_q == BURST);
    own_valid = req_valid[gidx_q];
    own_last  = req_last[gidx_q];
    xfer      = in_burst & own_valid & ~wfull;
    winc      = xfer;
    req_ready = (in_burst && !wfull) ? grant_q : '0;
    wdata     = in_burst ? req_data[gidx_q*DSIZE +: DSIZE] : '0;
    grant     = grant_q;
    busy      = in_burst;
    ptr_inc   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
  end

  // Next-state logic for the IDLE/BURST controller.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    if (state_q == IDLE) begin
      if (win_found && (!GATE_EN || !awfull)) begin
        state_d = BURST;
        grant_d = NREQ'(1) << win_idx;
        gidx_d  = win_idx;
        bcnt_d  = '0;
      end
    end else begin
      if (!own_valid) begin
        // Owner withdrew: release the grant and move on.
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = ptr_inc;
        bcnt_d  = '0;
      end else if (!wfull) begin
        if (own_last || bcnt_q == BCNT_END) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_inc;
          bcnt_d  = '0;
        end else begin
          bcnt_d  = bcnt_q + 1'b1;
        end
      end
    end
  end

  // Controller state registers; reset abandons any burst in progress.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter in the write clock domain. It shares the single write port of the team's asynchronous FIFO (winc/wdata/wfull/awfull) among NREQ requesters.
- Each requester uses a valid/ready handshake with an optional end-of-burst marker.
- A grant is held for a burst of up to MAXBURST beats. Writes are throttled by the FIFO's registered full flag, and new grants can optionally be gated by its almost-full flag.

Parameters:
NREQ, 4, number of requesters (2..8)
DSIZE, 8, data width; matches the FIFO DSIZE
MAXBURST, 4, max beats per grant (>=1)
AWFULL_GATE, "TRUE", "TRUE": no new grant while awfull=1; "FALSE": awfull ignored

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a beat
req_last  in  NREQ  requester i's current beat ends its burst
req_data  in  NREQ*DSIZE  requester i data at [i*DSIZE +: DSIZE]
req_ready  out  NREQ  beat from requester i accepted this cycle
wfull  in  1  FIFO full (registered, write domain)
awfull  in  1  FIFO almost-full
winc  out  1  FIFO write strobe
wdata  out  DSIZE  FIFO write data
grant  out  NREQ  registered one-hot current owner; 0 when idle
busy  out  1  1 while in BURST

Behaviour:
- Reset (async, wrst_n=0): state=IDLE, grant=0, busy=0, rr pointer ptr=0, beat count bcnt=0. Combinational outputs follow: winc=0, req_ready=0, wdata=0. A reset mid-burst abandons the burst; no partial state is kept.
- FSM states: IDLE, BURST.
- IDLE:
  - No ready, winc=0, wdata=0.
  - If any req_valid is set, and (AWFULL_GATE="FALSE" or awfull=0): winner g = first index from ptr upward, modulo NREQ, with req_valid=1.
  - Next edge: grant<=onehot(g), bcnt<=0, state<=BURST.
  - Arbitration latency is 1 cycle from valid to grant. No beat transfers in IDLE.
- BURST, owner g:
  - wdata = req_data[g].
  - req_ready[g] = ~wfull; all other ready bits are 0.
  - winc = req_valid[g] & ~wfull. A transfer occurs when winc=1.
  - Transfer, not ending: bcnt<=bcnt+1.
  - Transfer with req_last[g]=1 or bcnt==MAXBURST-1: burst ends. grant<=0, state<=IDLE, ptr<=(g+1) mod NREQ, bcnt<=0.
  - wfull=1 with req_valid[g]=1: stall. No transfer; grant and bcnt hold; no timeout.
  - req_valid[g]=0: abandon. No transfer; grant<=0, state<=IDLE, ptr<=(g+1) mod NREQ.
- Width rules:
  - bcnt width = $clog2(MAXBURST+1); it never exceeds MAXBURST-1.
  - ptr width = $clog2(NREQ); it wraps NREQ-1 -> 0.
- Invariants:
  - winc is never 1 while wfull=1.
  - grant is always one-hot or zero.
  - At most one req_ready bit is set.
  - winc == |(req_ready & req_valid).
- Throughput: sustained MAXBURST beats per MAXBURST+1 cycles; one IDLE cycle between grants.
- wfull rise after the filling write: wfull is registered by the FIFO, so the next beat simply stalls; no beat is lost or duplicated.
- Requester rules:
  - Requesters must hold req_data/req_last stable while req_valid=1 and not accepted.
  - Dropping req_valid before last is legal and releases the grant.
- Fairness: a requester waits at most (NREQ-1)*(MAXBURST+1) cycles for a grant while awfull/wfull stay low.

Test Plan:
- Req 0 alone with beats A0,A1,A2, last on A2, MAXBURST=4 -> grant=0001 one cycle after valid; winc high 3 cycles with wdata A0,A1,A2; then grant=0, ptr=1.
- All 4 requesters valid continuously, no last -> grant sequence 0001,0010,0100,1000,0001. Each grant gives exactly 4 transfers with one idle cycle between grants; 16 writes in 20 cycles.
- wfull=1 for 2 cycles after beat 2 of a burst from req 1 -> winc=0 and req_ready=0 those cycles, grant holds at 0010, bcnt holds. Beats 3-4 follow after wfull falls, then release.
- AWFULL_GATE="TRUE", awfull=1 in IDLE with req_valid=0100 -> grant stays 0 until awfull=0, then grant=0100 next cycle. AWFULL_GATE="FALSE" -> grant=0100 immediately.
- Req 2 drops req_valid after 1 beat while req 3 is valid -> grant=0 next cycle, then 1000; req 2 sees exactly 1 accepted beat.
- wrst_n pulsed low mid-burst from req 3 -> grant, busy, winc, req_ready go to 0 asynchronously. After release with all valid, first grant=0001.
